// File: rtl/verinject_classifier_pkg.sv
// Shared encodings for the golden/injected divergence classifier.
package verinject_classifier_pkg;

    localparam logic [1:0] CLASS_MASKED    = 2'd0;
    localparam logic [1:0] CLASS_RECOVERED = 2'd1;
    localparam logic [1:0] CLASS_FAILED    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WATCH    = 2'd1,
        ST_DIVERGED = 2'd2
    } state_t;

endpackage

// File: rtl/verinject_divergence_classifier.sv
// Watches golden vs injected output buses after each injection and emits one
// classified result record (MASKED / RECOVERED / FAILED) per injection.
module verinject_divergence_classifier
    import verinject_classifier_pkg::*;
#(
    parameter int DATA_W = 40,
    parameter int CYC_W  = 48,
    parameter int WINDOW = 256,
    parameter int RECONV = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CYC_W-1:0]  cycle_number,
    input  logic              inject_fire,
    input  logic [DATA_W-1:0] golden_data,
    input  logic [DATA_W-1:0] test_data,
    output logic              busy,
    output logic              result_valid,
    output logic [1:0]        result_class,
    output logic              result_overrun,
    output logic [CYC_W-1:0]  inject_cycle,
    output logic [CYC_W-1:0]  first_diverge_cycle,
    output logic [DATA_W-1:0] first_diff,
    output logic [CNT_W-1:0]  mismatch_cycles
);

    localparam int TMR_W = $clog2(WINDOW) + 1;
    localparam int RUN_W = $clog2(RECONV + 1);

    generate
        if (WINDOW < 2 || RECONV < 1) begin : g_param_check
            $error("verinject_divergence_classifier: WINDOW must be >= 2 and RECONV >= 1");
        end
    endgenerate

    state_t            state;
    state_t            state_next;
    logic [TMR_W-1:0]  timer;
    logic [RUN_W-1:0]  match_run;
    logic              mismatch;
    logic              deadline;
    logic              recovered;
    logic              emit;
    logic [1:0]        emit_class;

    assign mismatch  = (golden_data != test_data);
    // timer counts samples already taken; this sample is the last one in the window
    assign deadline  = (timer == TMR_W'(WINDOW - 2));
    assign recovered = !mismatch && (match_run == RUN_W'(RECONV - 1));
    assign busy      = (state != ST_IDLE);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state and verdict decision; recovery takes priority over the window deadline.
    always_comb begin
        state_next = state;
        emit       = 1'b0;
        emit_class = CLASS_MASKED;
        case (state)
            ST_IDLE: begin
                if (inject_fire) state_next = ST_WATCH;
            end
            ST_WATCH: begin
                if (mismatch) begin
                    if (deadline) begin
                        emit       = 1'b1;
                        emit_class = CLASS_FAILED;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_DIVERGED;
                    end
                end else if (deadline) begin
                    emit       = 1'b1;
                    emit_class = CLASS_MASKED;
                    state_next = ST_IDLE;
                end
            end
            ST_DIVERGED: begin
                if (recovered) begin
                    emit       = 1'b1;
                    emit_class = CLASS_RECOVERED;
                    state_next = ST_IDLE;
                end else if (deadline) begin
                    emit       = 1'b1;
                    emit_class = CLASS_FAILED;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Record fields, timer, match run and saturating mismatch counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            result_valid        <= 1'b0;
            result_class        <= CLASS_MASKED;
            result_overrun      <= 1'b0;
            inject_cycle        <= '0;
            first_diverge_cycle <= '0;
            first_diff          <= '0;
            mismatch_cycles     <= '0;
            timer               <= '0;
            match_run           <= '0;
        end else begin
            result_valid <= emit;
            if (emit) result_class <= emit_class;
            case (state)
                ST_IDLE: begin
                    if (inject_fire) begin
                        inject_cycle        <= cycle_number;
                        result_class        <= CLASS_MASKED;
                        result_overrun      <= 1'b0;
                        first_diverge_cycle <= '0;
                        first_diff          <= '0;
                        mismatch_cycles     <= '0;
                        timer               <= '0;
                        match_run           <= '0;
                    end
                end
                ST_WATCH, ST_DIVERGED: begin
                    if (inject_fire) result_overrun <= 1'b1;
                    timer <= timer + TMR_W'(1);
                    if (mismatch) begin
                        match_run <= '0;
                        if (state == ST_WATCH) begin
                            first_diverge_cycle <= cycle_number;
                            first_diff          <= golden_data ^ test_data;
                            mismatch_cycles     <= CNT_W'(1);
                        end else if (mismatch_cycles != '1) begin
                            mismatch_cycles <= mismatch_cycles + CNT_W'(1);
                        end
                    end else if (state == ST_DIVERGED) begin
                        match_run <= match_run + RUN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_verinject_divergence_classifier.sv
// Directed bench for the divergence classifier: table of injection scenarios
// plus hand sequences for reset, back-to-back fire and mid-observation reset.
module tb_verinject_divergence_classifier;

    localparam int DATA_W = 40;
    localparam int CYC_W  = 48;
    localparam int WINDOW = 256;
    localparam int RECONV = 8;
    localparam int CNT_W  = 16;
    localparam int SAT_W  = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [CYC_W-1:0]  cycle_number;
    logic              inject_fire;
    logic [DATA_W-1:0] golden_data;
    logic [DATA_W-1:0] test_data;

    logic              busy, result_valid, result_overrun;
    logic [1:0]        result_class;
    logic [CYC_W-1:0]  inject_cycle, first_diverge_cycle;
    logic [DATA_W-1:0] first_diff;
    logic [CNT_W-1:0]  mismatch_cycles;

    logic              b_busy, b_result_valid, b_result_overrun;
    logic [1:0]        b_result_class;
    logic [CYC_W-1:0]  b_inject_cycle, b_first_diverge_cycle;
    logic [DATA_W-1:0] b_first_diff;
    logic [SAT_W-1:0]  b_mismatch_cycles;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    verinject_divergence_classifier #(
        .DATA_W(DATA_W), .CYC_W(CYC_W), .WINDOW(WINDOW), .RECONV(RECONV), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .cycle_number(cycle_number), .inject_fire(inject_fire),
        .golden_data(golden_data), .test_data(test_data), .busy(busy),
        .result_valid(result_valid), .result_class(result_class),
        .result_overrun(result_overrun), .inject_cycle(inject_cycle),
        .first_diverge_cycle(first_diverge_cycle), .first_diff(first_diff),
        .mismatch_cycles(mismatch_cycles)
    );

    verinject_divergence_classifier #(
        .DATA_W(DATA_W), .CYC_W(CYC_W), .WINDOW(WINDOW), .RECONV(RECONV), .CNT_W(SAT_W)
    ) dut_sat (
        .clock(clock), .reset(reset), .cycle_number(cycle_number), .inject_fire(inject_fire),
        .golden_data(golden_data), .test_data(test_data), .busy(b_busy),
        .result_valid(b_result_valid), .result_class(b_result_class),
        .result_overrun(b_result_overrun), .inject_cycle(b_inject_cycle),
        .first_diverge_cycle(b_first_diverge_cycle), .first_diff(b_first_diff),
        .mismatch_cycles(b_mismatch_cycles)
    );

    typedef struct {
        int          fire;
        int          fire2;
        int          lo;
        int          hi;
        int          lo2;
        int          hi2;
        logic [39:0] pat;
        int          exp_valid;
        int          exp_class;
        int          exp_first;
        logic [39:0] exp_diff;
        int          exp_mm;
        int          exp_ov;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cycle_number = cycle_number + 1;
    endtask

    // Drive one cycle of stimulus; the injected bus differs by pat when flip is set.
    task automatic drive(input bit fire, input bit flip, input logic [39:0] pat);
        inject_fire = fire;
        golden_data = {cycle_number[7:0], cycle_number[31:0] ^ 32'hC0DE_0000};
        test_data   = flip ? (golden_data ^ pat) : golden_data;
    endtask

    function automatic bit in_rng(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int          n_a = 0;
        int          n_b = 0;
        int          vcyc = -1;
        logic [1:0]  cls = '0;
        logic [1:0]  b_cls = '0;
        logic        ov = 1'b0;
        logic [47:0] fdc = '0;
        logic [47:0] ic = '0;
        logic [39:0] diff = '0;
        logic [15:0] mm = '0;
        logic [3:0]  b_mm = '0;
        int          c;
        int          sat_mm;
        cycle_number = 48'd90;
        while (int'(cycle_number) < v.fire + WINDOW + 20) begin
            c = int'(cycle_number);
            drive((c == v.fire) || (c == v.fire2),
                  in_rng(c, v.lo, v.hi) || in_rng(c, v.lo2, v.hi2), v.pat);
            tick();
            if (result_valid) begin
                n_a++;
                if (n_a == 1) begin
                    vcyc = int'(cycle_number); cls = result_class; ov = result_overrun;
                    fdc = first_diverge_cycle; diff = first_diff; mm = mismatch_cycles;
                    ic = inject_cycle;
                end
            end
            if (b_result_valid) begin
                n_b++;
                if (n_b == 1) begin b_cls = b_result_class; b_mm = b_mismatch_cycles; end
            end
        end
        drive(1'b0, 1'b0, '0);
        sat_mm = (v.exp_mm > 15) ? 15 : v.exp_mm;
        check($sformatf("v%0d.count", idx), n_a, 1);
        check($sformatf("v%0d.valid_cycle", idx), vcyc, v.exp_valid);
        check($sformatf("v%0d.class", idx), cls, v.exp_class);
        check($sformatf("v%0d.first_cycle", idx), fdc, v.exp_first);
        check($sformatf("v%0d.first_diff", idx), diff, v.exp_diff);
        check($sformatf("v%0d.mismatch_cycles", idx), mm, v.exp_mm);
        check($sformatf("v%0d.overrun", idx), ov, v.exp_ov);
        check($sformatf("v%0d.inject_cycle", idx), ic, v.fire);
        check($sformatf("v%0d.sat_count", idx), n_b, 1);
        check($sformatf("v%0d.sat_class", idx), b_cls, v.exp_class);
        check($sformatf("v%0d.sat_mismatch_cycles", idx), b_mm, sat_mm);
        check($sformatf("v%0d.hold_class", idx), result_class, v.exp_class);
        check($sformatf("v%0d.hold_busy", idx), busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_res;
        //          fire fire2 lo   hi      lo2  hi2  pat                valid cls first diff               mm   ov
        vecs[0] = '{100, -1,  -1,  -2,     -1,  -2,  40'h0,             356,  0,  0,    40'h0,             0,   0};
        vecs[1] = '{100, -1,  103, 105,    -1,  -2,  40'h00_0000_0010,  114,  1,  103,  40'h00_0000_0010,  3,   0};
        vecs[2] = '{100, -1,  110, 100000, -1,  -2,  40'h80_0000_0001,  356,  2,  110,  40'h80_0000_0001,  246, 0};
        vecs[3] = '{100, 150, -1,  -2,     -1,  -2,  40'h0,             356,  0,  0,    40'h0,             0,   1};
        vecs[4] = '{100, -1,  95,  100,    -1,  -2,  40'h00_0000_00FF,  356,  0,  0,    40'h0,             0,   0};
        vecs[5] = '{100, -1,  101, 101,    -1,  -2,  40'h00_0000_FF00,  110,  1,  101,  40'h00_0000_FF00,  1,   0};
        vecs[6] = '{100, -1,  300, 347,    -1,  -2,  40'h00_0000_0001,  356,  1,  300,  40'h00_0000_0001,  48,  0};
        vecs[7] = '{100, -1,  300, 348,    -1,  -2,  40'h00_0000_0001,  356,  2,  300,  40'h00_0000_0001,  49,  0};
        vecs[8] = '{100, -1,  103, 103,    108, 108, 40'h20_0000_0000,  117,  1,  103,  40'h20_0000_0000,  2,   0};
        vecs[9] = '{100, 105, 103, 105,    -1,  -2,  40'h00_0000_0010,  114,  1,  103,  40'h00_0000_0010,  3,   1};

        // Reset state
        cycle_number = 48'd0;
        reset = 1'b1;
        drive(1'b0, 1'b0, '0);
        repeat (3) tick();
        check("rst.busy", busy, 0);
        check("rst.valid", result_valid, 0);
        check("rst.class", result_class, 0);
        check("rst.inject_cycle", inject_cycle, 0);
        check("rst.first_diff", first_diff, 0);
        check("rst.mismatch_cycles", mismatch_cycles, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Fire on the result_valid cycle starts a fresh, non-overrun record
        n_res = 0;
        cycle_number = 48'd90;
        while (int'(cycle_number) < 640) begin
            drive((int'(cycle_number) == 100) || (int'(cycle_number) == 356), 1'b0, '0);
            tick();
            if (result_valid) begin
                n_res++;
                if (n_res == 1) begin
                    check("b2b.first_cycle", cycle_number, 356);
                    check("b2b.first_ic", inject_cycle, 100);
                end else begin
                    check("b2b.second_cycle", cycle_number, 612);
                    check("b2b.second_ic", inject_cycle, 356);
                    check("b2b.second_ov", result_overrun, 0);
                    check("b2b.second_class", result_class, 0);
                end
            end
            if (int'(cycle_number) == 357) begin
                check("b2b.busy", busy, 1);
                check("b2b.restart_ic", inject_cycle, 356);
                check("b2b.restart_ov", result_overrun, 0);
            end
        end
        check("b2b.count", n_res, 2);

        // Reset mid-DIVERGED aborts the record
        n_res = 0;
        cycle_number = 48'd90;
        while (int'(cycle_number) < 120) begin
            drive(int'(cycle_number) == 100, int'(cycle_number) >= 110, 40'h00_0000_0004);
            tick();
            if (result_valid) n_res++;
        end
        check("rstmid.busy_before", busy, 1);
        reset = 1'b1;
        drive(1'b0, 1'b1, 40'h00_0000_0004);
        tick();
        reset = 1'b0;
        check("rstmid.busy", busy, 0);
        check("rstmid.valid", result_valid, 0);
        check("rstmid.inject_cycle", inject_cycle, 0);
        check("rstmid.first_cycle", first_diverge_cycle, 0);
        check("rstmid.first_diff", first_diff, 0);
        check("rstmid.mismatch_cycles", mismatch_cycles, 0);
        check("rstmid.overrun", result_overrun, 0);
        while (int'(cycle_number) < 400) begin
            drive(1'b0, 1'b1, 40'h00_0000_0004);
            tick();
            if (result_valid) n_res++;
        end
        check("rstmid.no_result", n_res, 0);
        while (int'(cycle_number) < 700) begin
            drive(int'(cycle_number) == 410, 1'b0, '0);
            tick();
            if (result_valid) begin
                n_res++;
                check("rstmid.after_cycle", cycle_number, 666);
                check("rstmid.after_ic", inject_cycle, 410);
                check("rstmid.after_class", result_class, 0);
                check("rstmid.after_mm", mismatch_cycles, 0);
            end
        end
        check("rstmid.after_count", n_res, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/verinject_divergence_classifier.md
Name: verinject_divergence_classifier

Overview:
- Synthesizable consumer stage downstream of the paired golden/injected DUT instances and the injector.
- Compares the golden output bus against the injected output bus every cycle after each injection event.
- Classifies each injection outcome as MASKED, RECOVERED or FAILED, and emits one result record per injection.
- Replaces ad-hoc testbench mismatch printing with a countable, loggable outcome stream.

Parameters:
- DATA_W, 40, width of the compared output bus (e.g. 8-bit index concatenated with 32-bit sum).
- CYC_W, 48, width of cycle_number.
- WINDOW, 256, observation cycles after an injection before the verdict is forced.
- RECONV, 8, consecutive matching cycles after a divergence required to declare RECOVERED.
- CNT_W, 16, width of the mismatch-cycle counter (saturating).

Ports:
- clock, input, 1, sole clock.
- reset, input, 1, synchronous, active-high.
- cycle_number, input, CYC_W, free-running cycle count from the injector.
- inject_fire, input, 1, single-cycle pulse; the injector applies a fault this cycle.
- golden_data, input, DATA_W, output of the non-injected DUT.
- test_data, input, DATA_W, output of the injected DUT.
- busy, output, 1, observation in progress.
- result_valid, output, 1, one-cycle pulse; the result fields are valid.
- result_class, output, 2, 0=MASKED, 1=RECOVERED, 2=FAILED (3 unused).
- result_overrun, output, 1, inject_fire arrived while busy during this record.
- inject_cycle, output, CYC_W, cycle_number sampled at inject_fire.
- first_diverge_cycle, output, CYC_W, cycle_number of the first mismatch; 0 if none.
- first_diff, output, DATA_W, golden_data XOR test_data at the first mismatch.
- mismatch_cycles, output, CNT_W, number of mismatching cycles in the window; saturates at all-ones.

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0. Reset mid-observation aborts the record; no result is emitted.
- mismatch = (golden_data != test_data), combinational, sampled on each rising edge.
- IDLE:
  - Mismatches are ignored.
  - On inject_fire: latch inject_cycle; clear timer, counters, first_* and overrun; go to WATCH.
  - The comparison starts on the cycle after inject_fire. The fire cycle itself is not compared.
- WATCH: timer increments each cycle.
  - On mismatch: latch first_diverge_cycle and first_diff, set mismatch_cycles=1, clear the match run counter, go to DIVERGED.
  - If timer reaches WINDOW-1 with no mismatch: emit MASKED.
- DIVERGED: timer increments.
  - On mismatch: mismatch_cycles increments (saturating) and the match run resets to 0.
  - On match: the match run increments.
  - When the match run reaches RECONV: emit RECOVERED.
  - If timer reaches WINDOW-1 first: emit FAILED.
  - If both conditions occur in the same cycle, RECOVERED wins.
- Emit: result_valid=1 for exactly one cycle, registered (the cycle after the deciding sample). busy falls in the same cycle and the state returns to IDLE.
  - result_* fields hold their values until the next inject_fire is accepted.
- inject_fire while busy:
  - Not restarted; set result_overrun.
  - inject_cycle is unchanged.
- inject_fire on the result_valid cycle (state already IDLE): accepted as a new injection.
- busy=1 in WATCH and DIVERGED only.
- Timer width: $clog2(WINDOW)+1. Both WINDOW>=2 and RECONV>=1 are required; check them with an elaboration-time assertion.

Decomposition:
- Package verinject_classifier_pkg: result_class encoding constants (CLASS_MASKED, CLASS_RECOVERED, CLASS_FAILED); state enum (ST_IDLE, ST_WATCH, ST_DIVERGED).
- No sub-module needed. The saturating counter stays inline.

Test Plan:
- No fault: fire at cycle 100, data always equal, WINDOW=256 -> result_valid at ~cycle 357, class=0, mismatch_cycles=0, first_diverge_cycle=0.
- Transient: fire at 100, test_data ^= 40'h00_0000_0010 for cycles 103–105 only, RECONV=8 -> class=1, first_diverge_cycle=103, first_diff=40'h10, mismatch_cycles=3, result_valid the cycle after 113.
- Persistent: fire at 100, mismatch from 110 onward -> class=2 at window end, mismatch_cycles=WINDOW-10 (246).
- Overrun: second fire at 150 during WATCH -> a single result with result_overrun=1 and inject_cycle=100. A fire on the result_valid cycle starts a fresh record with overrun=0.
- Reset mid-DIVERGED at cycle 120 -> no result_valid, busy=0 and all outputs 0 the next cycle. A subsequent fire works normally.
- Saturation: CNT_W=4, persistent mismatch -> mismatch_cycles=15, class=2.
